// File: rtl/pcxt_clk_en_gen.sv
// Lock-qualified reset sequencer and single-clock CE generator for a PC/XT core.
// Optional macro PCXT_LOCK_LOSS_CNT_EN adds a saturating lock-loss event counter.
module pcxt_clk_en_gen #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic [1:0] turbo_sel,
    output logic       cpu_ce,
    output logic       periph_ce,
    output logic       pit_ce,
    output logic       sys_rst_n,
    output logic [1:0] cpu_mode,
    output logic       lock_lost,
    output logic [7:0] lock_loss_cnt
);

    localparam int SCNT_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int HCNT_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [SCNT_W-1:0] STABLE_LAST = SCNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST   = HCNT_W'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_sync1;
    logic              r_locked_s;
    logic [SCNT_W-1:0] r_stable_cnt;
    logic [HCNT_W-1:0] r_hold_cnt;
    logic [3:0]        r_d12;
    logic [1:0]        r_cdiv;
    logic [1:0]        r_cpu_mode;
    logic              r_sys_rst_n;
    logic              r_lock_lost;
    logic              w_active;
    logic              w_hold_entry;
    logic              w_loss;
    logic              w_cpu_ce;
    logic [1:0]        w_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= pll_locked;
            r_locked_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_LOCK;
        else        r_state <= w_next;
    end

    // Loss of synchronised lock overrides every other transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_LOCK: if (r_locked_s) w_next = STABLE;
            STABLE:    if (r_locked_s && r_stable_cnt == STABLE_LAST) w_next = HOLD;
            HOLD:      if (r_hold_cnt == HOLD_LAST) w_next = RUN;
            RUN:       w_next = RUN;
            default:   w_next = WAIT_LOCK;
        endcase
        if (r_state != WAIT_LOCK && !r_locked_s) w_next = WAIT_LOCK;
    end

    assign w_active     = (r_state == HOLD) || (r_state == RUN);
    assign w_hold_entry = (r_state == STABLE) && (w_next == HOLD);
    assign w_loss       = w_active && !r_locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            r_stable_cnt <= (r_state == STABLE) ? r_stable_cnt + 1'b1 : '0;
            r_hold_cnt   <= (r_state == HOLD)   ? r_hold_cnt + 1'b1   : '0;
        end
    end

    // Code 11 runs as div3 but is still reported as 11 on cpu_mode.
    always_comb begin
        case (r_cpu_mode)
            2'b10:   w_tc = 2'd0;
            2'b01:   w_tc = 2'd1;
            default: w_tc = 2'd2;
        endcase
    end

    assign w_cpu_ce = w_active && (r_cdiv == w_tc);

    // turbo_sel is only taken at a period boundary so every CPU period is whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d12      <= 4'd0;
            r_cdiv     <= 2'd0;
            r_cpu_mode <= 2'b00;
        end else if (w_hold_entry) begin
            r_d12      <= 4'd0;
            r_cdiv     <= 2'd0;
            r_cpu_mode <= turbo_sel;
        end else if (w_active) begin
            r_d12 <= (r_d12 == 4'd11) ? 4'd0 : r_d12 + 4'd1;
            if (w_cpu_ce) begin
                r_cdiv     <= 2'd0;
                r_cpu_mode <= turbo_sel;
            end else begin
                r_cdiv <= r_cdiv + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sys_rst_n <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_sys_rst_n <= (w_next == RUN);
            r_lock_lost <= w_loss;
        end
    end

`ifdef PCXT_LOCK_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_loss_cnt <= 8'd0;
        else if (w_loss && r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'd1;
    end

    assign lock_loss_cnt = r_loss_cnt;
`else
    assign lock_loss_cnt = 8'd0;
`endif

    assign cpu_ce    = w_cpu_ce;
    assign periph_ce = w_active && (r_d12 == 4'd5 || r_d12 == 4'd11);
    assign pit_ce    = w_active && (r_d12 == 4'd11);
    assign sys_rst_n = r_sys_rst_n;
    assign cpu_mode  = r_cpu_mode;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_pcxt_clk_en_gen.sv
// Randomised bench for pcxt_clk_en_gen against a timeline-based reference model.
module tb_pcxt_clk_en_gen;

    localparam int L = 8;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic [1:0] turbo_sel = 2'b00;
    logic       cpu_ce, periph_ce, pit_ce, sys_rst_n, lock_lost;
    logic [1:0] cpu_mode;
    logic [7:0] lock_loss_cnt;

    pcxt_clk_en_gen #(.LOCK_STABLE_CYCLES(L), .RST_HOLD_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .turbo_sel(turbo_sel),
        .cpu_ce(cpu_ce), .periph_ce(periph_ce), .pit_ce(pit_ce), .sys_rst_n(sys_rst_n),
        .cpu_mode(cpu_mode), .lock_lost(lock_lost), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Model: m_t counts cycles since STABLE entry; HOLD starts at m_t==L, RUN at L+H.
    bit         m_s1, m_s2, m_seq, m_lost;
    int         m_t, m_start, m_cnt;
    logic [1:0] m_mode;

    function automatic int period(input logic [1:0] md);
        case (md)
            2'b10:   return 1;
            2'b01:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit m_active();
        return m_seq && (m_t >= L);
    endfunction

    function automatic bit m_cpu();
        return m_active() && (((m_t - L) - m_start) == period(m_mode) - 1);
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_seq = 0; m_lost = 0;
        m_t = 0; m_start = 0; m_cnt = 0; m_mode = 2'b00;
    endtask

    task automatic model_edge();
        bit act, ce, ls;
        act = m_active();
        ce  = m_cpu();
        ls  = m_s2;
        m_lost = 0;
        if (act && ce) begin
            m_mode  = turbo_sel;
            m_start = (m_t - L) + 1;
        end
        if (!m_seq) begin
            if (ls) begin
                m_seq = 1;
                m_t   = 0;
            end
        end else if (!ls) begin
            m_lost = act;
            m_seq  = 0;
`ifdef PCXT_LOCK_LOSS_CNT_EN
            if (act && m_cnt < 255) m_cnt++;
`endif
        end else begin
            m_t++;
            if (m_t == L) begin
                m_mode  = turbo_sel;
                m_start = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = pll_locked;
    endtask

    task automatic check_all();
        int a;
        a = m_t - L;
        chk("cpu_ce",    cpu_ce,    m_cpu());
        chk("periph_ce", periph_ce, m_active() && (a % 12 == 5 || a % 12 == 11));
        chk("pit_ce",    pit_ce,    m_active() && (a % 12 == 11));
        chk("sys_rst_n", sys_rst_n, m_seq && (m_t >= L + H));
        chk("cpu_mode",  cpu_mode,  m_mode);
        chk("lock_lost", lock_lost, m_lost);
        chk("loss_cnt",  lock_loss_cnt, m_cnt);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cpu_ce"},    cpu_ce, 0);
        chk({tag, "_periph_ce"}, periph_ce, 0);
        chk({tag, "_pit_ce"},    pit_ce, 0);
        chk({tag, "_sys_rst_n"}, sys_rst_n, 0);
        chk({tag, "_cpu_mode"},  cpu_mode, 0);
        chk({tag, "_lock_lost"}, lock_lost, 0);
        chk({tag, "_loss_cnt"},  lock_loss_cnt, 0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    initial begin
        bit reached;
        model_reset();
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Power-up lock, then turbo changes landing at random points in a period.
        step(3);
        pll_locked = 1'b1;
        step(40);
        step($urandom_range(0, 2));
        turbo_sel = 2'b01;
        step(20);
        turbo_sel = 2'b10;
        step(10);
        turbo_sel = 2'b11;
        step(15);
        turbo_sel = 2'b00;
        step(7);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        step(6);

        // Glitchy lock: 5 high, 1 low, then held.
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(40);

        // Async reset while in HOLD.
        pll_locked = 1'b0;
        step(4);
        pll_locked = 1'b1;
        reached = 0;
        for (int i = 0; i < 50 && !reached; i++) begin
            step(1);
            if (m_seq && m_t == L + 1) reached = 1;
        end
        chk("reach_hold", reached, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(30);

        // Random lock drops and turbo changes.
        for (int i = 0; i < 3000; i++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 59) == 0) pll_locked = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                pll_locked = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) turbo_sel = 2'($urandom_range(0, 3));
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
